// File: rtl/eeprom_writer.sv
// Write controller for the AT93C86A Microwire EEPROM (x8): EWEN, WRITE, busy poll, EWDS.
// Drives cs/clk/di from registers so the pins never glitch while the top-level mux owns them.
module eeprom_writer #(
    parameter int HALF_PERIOD    = 8,
    parameter int CS_LOW_CYCLES  = 4,
    parameter int TIMEOUT_CYCLES = 120000
) (
    input  logic        raw_clk,
    input  logic        reset_n,
    input  logic [10:0] address,
    input  logic [7:0]  data_in,
    input  logic        strobe,
    output logic        eeprom_cs,
    output logic        eeprom_clk,
    output logic        eeprom_di,
    input  logic        eeprom_do,
    output logic        ready,
    output logic        done,
    output logic        error
);

    localparam int              PH_MAX       = (HALF_PERIOD > CS_LOW_CYCLES) ? HALF_PERIOD : CS_LOW_CYCLES;
    localparam int              PH_W         = $clog2(PH_MAX + 1);
    localparam logic [PH_W-1:0] HALF_LAST    = PH_W'(HALF_PERIOD - 1);
    localparam logic [PH_W-1:0] GAP_LAST     = PH_W'(CS_LOW_CYCLES - 1);
    localparam logic [16:0]     TIMEOUT_LAST = 17'(TIMEOUT_CYCLES - 1);
    localparam logic [13:0]     EWEN_FRAME   = 14'b10011_000000000;
    localparam logic [13:0]     EWDS_FRAME   = 14'b10000_000000000;
    localparam logic [4:0]      CMD_LAST     = 5'd13;
    localparam logic [4:0]      WRITE_LAST   = 5'd21;

    typedef enum logic [3:0] {
        IDLE,
        EWEN_SHIFT,
        GAP_A,
        WRITE_SHIFT,
        GAP_B,
        POLL,
        GAP_C,
        EWDS_SHIFT,
        FINISH
    } state_t;

    state_t          state_q;
    logic [21:0]     frame_q;
    logic [13:0]     cmd_q;
    logic [4:0]      bit_cnt_q;
    logic [PH_W-1:0] ph_cnt_q;
    logic [16:0]     tmo_cnt_q;
    logic            cs_q;
    logic            clk_q;
    logic            di_q;
    logic            ready_q;
    logic            done_q;
    logic            error_q;

    logic is_write;
    logic last_bit;
    logic next_bit;
    logic ph_last;
    logic gap_last;

    assign is_write = (state_q == WRITE_SHIFT);
    assign last_bit = (bit_cnt_q == (is_write ? WRITE_LAST : CMD_LAST));
    assign next_bit = is_write ? frame_q[21] : cmd_q[13];
    assign ph_last  = (ph_cnt_q == HALF_LAST);
    assign gap_last = (ph_cnt_q == GAP_LAST);

    // NOTE: every register, the frame shifters included, sits on the async reset so di is never X on the pin.
    always_ff @(posedge raw_clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q   <= IDLE;
            frame_q   <= '0;
            cmd_q     <= '0;
            bit_cnt_q <= '0;
            ph_cnt_q  <= '0;
            tmo_cnt_q <= '0;
            cs_q      <= 1'b0;
            clk_q     <= 1'b0;
            di_q      <= 1'b0;
            ready_q   <= 1'b1;
            done_q    <= 1'b0;
            error_q   <= 1'b0;
        end else begin
            // NOTE: done defaults low here so the single assignment entering FINISH yields a one-cycle pulse.
            done_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (strobe) begin
                        frame_q   <= {3'b101, address, data_in};
                        cmd_q     <= {EWEN_FRAME[12:0], 1'b0};
                        di_q      <= EWEN_FRAME[13];
                        cs_q      <= 1'b1;
                        clk_q     <= 1'b0;
                        bit_cnt_q <= '0;
                        ph_cnt_q  <= '0;
                        error_q   <= 1'b0;
                        ready_q   <= 1'b0;
                        state_q   <= EWEN_SHIFT;
                    end
                end

                EWEN_SHIFT, WRITE_SHIFT, EWDS_SHIFT: begin
                    if (!ph_last) begin
                        ph_cnt_q <= ph_cnt_q + 1'b1;
                    end else begin
                        ph_cnt_q <= '0;
                        if (!clk_q) begin
                            clk_q <= 1'b1;
                        end else begin
                            clk_q <= 1'b0;
                            if (last_bit) begin
                                di_q <= 1'b0;
                                cs_q <= 1'b0;
                                case (state_q)
                                    EWEN_SHIFT:  state_q <= GAP_A;
                                    WRITE_SHIFT: state_q <= GAP_B;
                                    default: begin
                                        state_q <= FINISH;
                                        done_q  <= 1'b1;
                                    end
                                endcase
                            end else begin
                                // di only moves on the falling half, giving the EEPROM a full half period of setup.
                                bit_cnt_q <= bit_cnt_q + 5'd1;
                                di_q      <= next_bit;
                                if (is_write) frame_q <= {frame_q[20:0], 1'b0};
                                else          cmd_q   <= {cmd_q[12:0], 1'b0};
                            end
                        end
                    end
                end

                GAP_A: begin
                    if (gap_last) begin
                        ph_cnt_q  <= '0;
                        bit_cnt_q <= '0;
                        cs_q      <= 1'b1;
                        di_q      <= frame_q[21];
                        frame_q   <= {frame_q[20:0], 1'b0};
                        state_q   <= WRITE_SHIFT;
                    end else begin
                        ph_cnt_q <= ph_cnt_q + 1'b1;
                    end
                end

                GAP_B: begin
                    if (gap_last) begin
                        ph_cnt_q  <= '0;
                        tmo_cnt_q <= '0;
                        cs_q      <= 1'b1;
                        state_q   <= POLL;
                    end else begin
                        ph_cnt_q <= ph_cnt_q + 1'b1;
                    end
                end

                POLL: begin
                    // A ready sample in the final cycle wins over the timeout.
                    if (ph_last && eeprom_do) begin
                        ph_cnt_q <= '0;
                        cs_q     <= 1'b0;
                        state_q  <= GAP_C;
                    end else if (tmo_cnt_q == TIMEOUT_LAST) begin
                        ph_cnt_q <= '0;
                        cs_q     <= 1'b0;
                        error_q  <= 1'b1;
                        state_q  <= GAP_C;
                    end else begin
                        tmo_cnt_q <= tmo_cnt_q + 17'd1;
                        ph_cnt_q  <= ph_last ? '0 : ph_cnt_q + 1'b1;
                    end
                end

                GAP_C: begin
                    if (gap_last) begin
                        ph_cnt_q  <= '0;
                        bit_cnt_q <= '0;
                        cs_q      <= 1'b1;
                        di_q      <= EWDS_FRAME[13];
                        cmd_q     <= {EWDS_FRAME[12:0], 1'b0};
                        state_q   <= EWDS_SHIFT;
                    end else begin
                        ph_cnt_q <= ph_cnt_q + 1'b1;
                    end
                end

                FINISH: begin
                    ready_q <= 1'b1;
                    state_q <= IDLE;
                end

                default: begin
                    cs_q    <= 1'b0;
                    clk_q   <= 1'b0;
                    di_q    <= 1'b0;
                    ready_q <= 1'b1;
                    state_q <= IDLE;
                end
            endcase
        end
    end

    assign eeprom_cs  = cs_q;
    assign eeprom_clk = clk_q;
    assign eeprom_di  = di_q;
    assign ready      = ready_q;
    assign done       = done_q;
    assign error      = error_q;

endmodule

// File: tb/tb_eeprom_writer.sv
// Bench for eeprom_writer: decodes the Microwire pins into frames and compares them, plus
// done latency and error, with a frame/poll model derived from the protocol rules.
module tb_eeprom_writer;

    localparam int HP  = 8;
    localparam int CSL = 4;
    localparam int TMO = 3000;
    localparam logic [31:0] EWEN_BITS = 32'b10011000000000;
    localparam logic [31:0] EWDS_BITS = 32'b10000000000000;
    localparam int NEVER_READY = 1 << 20;

    logic        raw_clk = 1'b0;
    logic        reset_n = 1'b0;
    logic [10:0] address = '0;
    logic [7:0]  data_in = '0;
    logic        strobe  = 1'b0;
    logic        eeprom_do = 1'b0;
    logic        eeprom_cs, eeprom_clk, eeprom_di, ready, done, error;

    eeprom_writer #(
        .HALF_PERIOD   (HP),
        .CS_LOW_CYCLES (CSL),
        .TIMEOUT_CYCLES(TMO)
    ) dut (
        .raw_clk   (raw_clk),
        .reset_n   (reset_n),
        .address   (address),
        .data_in   (data_in),
        .strobe    (strobe),
        .eeprom_cs (eeprom_cs),
        .eeprom_clk(eeprom_clk),
        .eeprom_di (eeprom_di),
        .eeprom_do (eeprom_do),
        .ready     (ready),
        .done      (done),
        .error     (error)
    );

    always #5 raw_clk = ~raw_clk;

    int cyc = 0;
    initial forever begin
        @(posedge raw_clk);
        cyc++;
    end

    int n_vec  = 0;
    int n_miss = 0;
    int s_cyc  = 0;
    int busy_len = 0;

    // Pin monitor / EEPROM status driver state
    int          seg_idx = -1;
    logic [31:0] seg_bits[4];
    int          seg_len[4];
    int          seg_start[4];
    int          gap_len[3];
    int          low_run = 0;
    int          clk_bad = 0;
    int          di_bad = 0;
    int          done_cnt = 0;
    int          done_cyc = 0;
    logic        done_err = 1'b0;
    logic        p_cs = 1'b0, p_clk = 1'b0, p_di = 1'b0, p_ready = 1'b1;

    initial forever begin
        @(negedge raw_clk);
        if (p_ready && !ready) begin
            seg_idx = -1; low_run = 0; clk_bad = 0; di_bad = 0; done_cnt = 0;
            for (int i = 0; i < 4; i++) begin
                seg_bits[i] = '0; seg_len[i] = 0; seg_start[i] = 0;
            end
            for (int i = 0; i < 3; i++) gap_len[i] = 0;
        end
        if (eeprom_cs && !p_cs) begin
            seg_idx++;
            if (seg_idx >= 1 && seg_idx <= 3) gap_len[seg_idx-1] = low_run;
            if (seg_idx >= 0 && seg_idx <= 3) seg_start[seg_idx] = cyc;
        end
        if (eeprom_cs) low_run = 0;
        else           low_run++;
        if (eeprom_clk && !p_clk) begin
            if (!eeprom_cs) clk_bad++;
            else if (seg_idx >= 0 && seg_idx <= 3) begin
                seg_bits[seg_idx] = {seg_bits[seg_idx][30:0], eeprom_di};
                seg_len[seg_idx]++;
            end
        end
        if (eeprom_clk && p_clk && (eeprom_di !== p_di)) di_bad++;
        if (done) begin
            done_cnt++;
            done_cyc = cyc;
            done_err = error;
        end
        // EEPROM reports busy for busy_len cycles after the status window opens; noise elsewhere.
        if (seg_idx == 2 && eeprom_cs) eeprom_do = ((cyc - seg_start[2]) >= busy_len);
        else                           eeprom_do = 1'($urandom_range(0, 1));
        p_cs = eeprom_cs; p_clk = eeprom_clk; p_di = eeprom_di; p_ready = ready;
    end

    initial begin
        #(10 * 60000);
        $display("FAIL watchdog: simulation exceeded 60000 cycles");
        $fatal(1, "watchdog expired");
    end

    // Reference model: status is sampled at the end of each HP window; timeout caps the poll.
    function automatic int poll_cycles(input int busy);
        int w;
        w = (busy / HP + 1) * HP;
        return (w > TMO) ? TMO : w;
    endfunction

    function automatic logic poll_err(input int busy);
        return ((busy / HP + 1) * HP) > TMO;
    endfunction

    function automatic int latency(input int busy);
        return 1 + (14 + 22 + 14) * 2 * HP + 3 * CSL + poll_cycles(busy);
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_miss++;
            $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic tick();
        @(negedge raw_clk);
        #1;
    endtask

    task automatic launch(input logic [10:0] a, input logic [7:0] d);
        int n = 0;
        while (!ready && n < 100) begin
            tick();
            n++;
        end
        check("ready_before_strobe", 32'(ready), 32'd1);
        strobe = 1'b1; address = a; data_in = d;
        s_cyc = cyc;
        tick();
        strobe = 1'b0;
        check("ready_after_strobe", 32'(ready), 32'd0);
        check("cs_after_strobe", 32'(eeprom_cs), 32'd1);
        check("first_di", 32'(eeprom_di), 32'd1);
        check("error_cleared", 32'(error), 32'd0);
    endtask

    task automatic wait_done(input logic [10:0] a, input logic [7:0] d, input int busy,
                             input int exp_lat, input logic exp_err, input bit spam,
                             input bit chain, input logic [10:0] a2, input logic [7:0] d2);
        int n = 0;
        while (done_cnt == 0 && n < TMO + 3000) begin
            tick();
            n++;
            if (spam && done_cnt == 0) begin
                if (seg_idx == 1 && eeprom_cs) begin
                    strobe  = 1'($urandom_range(0, 1));
                    address = 11'($urandom);
                    data_in = 8'($urandom);
                end else begin
                    strobe = 1'b0;
                end
            end
        end
        strobe = 1'b0;
        check("done_arrives", 32'(done_cnt), 32'd1);
        if (done_cnt == 0) return;
        if (chain) begin
            strobe = 1'b1; address = a2; data_in = d2;
        end
        check("latency", 32'(done_cyc - s_cyc), 32'(exp_lat));
        check("error_at_done", 32'(done_err), 32'(exp_err));
        check("segments", 32'(seg_idx + 1), 32'd4);
        check("ewen_len", 32'(seg_len[0]), 32'd14);
        check("ewen_bits", seg_bits[0], EWEN_BITS);
        check("write_len", 32'(seg_len[1]), 32'd22);
        check("write_bits", seg_bits[1], 32'({3'b101, a, d}));
        check("poll_clk_edges", 32'(seg_len[2]), 32'd0);
        check("poll_length", 32'(seg_start[3] - seg_start[2] - CSL), 32'(poll_cycles(busy)));
        check("ewds_len", 32'(seg_len[3]), 32'd14);
        check("ewds_bits", seg_bits[3], EWDS_BITS);
        for (int g = 0; g < 3; g++) check("cs_low_gap", 32'(gap_len[g]), 32'(CSL));
        check("clk_rise_cs_low", 32'(clk_bad), 32'd0);
        check("di_change_clk_high", 32'(di_bad), 32'd0);
        tick();
        check("ready_after_done", 32'(ready), 32'd1);
        check("done_one_cycle", 32'(done), 32'd0);
    endtask

    typedef struct {
        logic [10:0] addr;
        logic [7:0]  data;
        int          busy;
        int          exp_lat;
        logic        exp_err;
    } vec_t;

    vec_t tbl[5];

    initial begin
        logic [10:0] a;
        logic [7:0]  d;
        int          n;

        tbl[0] = '{11'h5A3, 8'hC7, 0, 821, 1'b0};
        tbl[1] = '{11'h7FF, 8'hFF, 1000, latency(1000), poll_err(1000)};
        tbl[2] = '{11'h000, 8'h00, HP - 1, latency(HP - 1), poll_err(HP - 1)};
        tbl[3] = '{11'h001, 8'h80, HP, latency(HP), poll_err(HP)};
        tbl[4] = '{11'h2AA, 8'h55, NEVER_READY, latency(NEVER_READY), poll_err(NEVER_READY)};

        repeat (3) tick();
        check("reset_outputs", 32'({eeprom_cs, eeprom_clk, eeprom_di, done, error, ready}), 32'b000001);
        reset_n = 1'b1;
        tick();
        check("idle_ready", 32'({ready, eeprom_cs}), 32'b10);

        for (int i = 0; i < 5; i++) begin
            busy_len = tbl[i].busy;
            launch(tbl[i].addr, tbl[i].data);
            wait_done(tbl[i].addr, tbl[i].data, tbl[i].busy, tbl[i].exp_lat, tbl[i].exp_err,
                      1'b0, 1'b0, 11'h0, 8'h0);
            if (tbl[i].exp_err) begin
                repeat (3) tick();
                check("error_sticky", 32'(error), 32'd1);
            end
        end

        for (int i = 0; i < 6; i++) begin
            a = 11'($urandom);
            d = 8'($urandom);
            busy_len = $urandom_range(0, 400);
            launch(a, d);
            wait_done(a, d, busy_len, latency(busy_len), poll_err(busy_len), 1'b0, 1'b0, 11'h0, 8'h0);
        end

        // Strobes during WRITE_SHIFT must not disturb the latched frame.
        busy_len = 20;
        launch(11'h3C5, 8'h9A);
        wait_done(11'h3C5, 8'h9A, 20, latency(20), 1'b0, 1'b1, 1'b0, 11'h0, 8'h0);

        // Strobe held across FINISH is only accepted once ready is high.
        busy_len = 0;
        launch(11'h111, 8'h22);
        wait_done(11'h111, 8'h22, 0, latency(0), 1'b0, 1'b0, 1'b1, 11'h6E1, 8'h3B);
        launch(11'h6E1, 8'h3B);
        wait_done(11'h6E1, 8'h3B, 0, latency(0), 1'b0, 1'b0, 1'b0, 11'h0, 8'h0);

        // Reset in the middle of the WRITE frame, then a clean operation.
        busy_len = 0;
        launch(11'h4D2, 8'hE1);
        n = 0;
        while (!(seg_idx == 1 && eeprom_clk && seg_len[1] >= 5) && n < 2000) begin
            tick();
            n++;
        end
        check("reach_write_shift", 32'(seg_idx), 32'd1);
        #1 reset_n = 1'b0;
        #1 check("async_reset_outputs", 32'({eeprom_cs, eeprom_clk, eeprom_di, done, error, ready}), 32'b000001);
        tick();
        reset_n = 1'b1;
        tick();
        check("idle_after_reset", 32'({ready, eeprom_cs, eeprom_clk}), 32'b100);
        launch(11'h0F0, 8'h5C);
        wait_done(11'h0F0, 8'h5C, 0, latency(0), 1'b0, 1'b0, 1'b0, 11'h0, 8'h0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule

// File: doc/eeprom_writer.md
# eeprom_writer

Write controller for the AT93C86A Microwire EEPROM in x8 organisation, the write-side counterpart of the existing EEPROM read path. On a single strobe it issues EWEN, then WRITE with an 11-bit address and 8-bit data, polls the self-timed busy status, then issues EWDS so the array is write-protected again. It drives the same four EEPROM pins as the reader; the top-level mux hands the pins to this block while `ready` is low.

## Interface
- HALF_PERIOD, 8: raw_clk cycles per eeprom_clk phase, giving 750 kHz at 12 MHz, below the 1 MHz limit.
- CS_LOW_CYCLES, 4: raw_clk cycles CS is held low between frames (tCS).
- TIMEOUT_CYCLES, 120000: raw_clk cycles allowed for busy polling, 10 ms at 12 MHz.
- raw_clk  in  1  system clock, 12 MHz.
- reset_n  in  1  asynchronous, active-low reset.
- address  in  11  byte address, latched on accepted strobe.
- data_in  in  8  byte to write, latched on accepted strobe.
- strobe  in  1  start request; accepted only when ready=1.
- eeprom_cs  out  1  chip select.
- eeprom_clk  out  1  serial clock.
- eeprom_di  out  1  serial data to EEPROM.
- eeprom_do  in  1  serial data from EEPROM; low = busy, high = ready during poll.
- ready  out  1  high in IDLE only.
- done  out  1  one-cycle pulse at completion.
- error  out  1  sticky timeout flag; cleared on next accepted strobe.

## Operation
- Frames are sent MSB first:
  - EWEN is 14 bits: 1 00 11 followed by 9 zeros.
  - WRITE is 22 bits: 1 01, then address[10:0], then data_in[7:0].
  - EWDS is 14 bits: 1 00 00 followed by 9 zeros.
- States: IDLE → EWEN_SHIFT → GAP_A → WRITE_SHIFT → GAP_B → POLL → GAP_C → EWDS_SHIFT → FINISH → IDLE.
- IDLE: outputs cs, clk and di are 0 and ready=1. On strobe the block latches address and data into a 22-bit shift register, clears error, and moves to EWEN_SHIFT.
- *_SHIFT states: cs=1. Each bit is HALF_PERIOD cycles with clk=0 and di driven, then HALF_PERIOD cycles with clk=1 and di held. The EEPROM samples on the rising edge, and di changes only while clk=0. A 5-bit bit counter sets the frame length. After the last bit the block drives clk=0 and di=0 and enters the following GAP state.
- GAP states: cs=0, clk=0, di=0 for CS_LOW_CYCLES cycles.
- POLL: cs=1, clk=0, di=0.
  - eeprom_do is sampled at the last cycle of each HALF_PERIOD window.
  - A sample of 1 exits to GAP_C.
  - A 17-bit timeout counter increments every cycle in POLL. When it reaches TIMEOUT_CYCLES the block sets error=1 and exits to GAP_C.
  - EWDS is always sent, including after a timeout.
- FINISH: cs=0 and done=1 for one cycle, then IDLE.
- A strobe while ready=0 is ignored; latched address and data do not change.
- A strobe on the same cycle as the FINISH→IDLE transition is not accepted. It is accepted if it is present on a cycle where ready=1.
- Reset mid-operation: all outputs return to their reset values asynchronously and the state goes to IDLE. A partially written byte is the caller's responsibility.

## Timing
- Reset values: eeprom_cs=0, eeprom_clk=0, eeprom_di=0, done=0, error=0, ready=1.
- BIT = 2*HALF_PERIOD, which is 16 cycles by default.
- cs rises on the cycle after strobe is accepted, and the first bit is presented on di in that same cycle.
- Fixed latency with no busy wait is 50*BIT + HALF_PERIOD + 3*CS_LOW_CYCLES, counted from the cycle after strobe to the done pulse. With defaults this is 821 cycles after the strobe cycle.
- Each additional poll window where eeprom_do=0 adds HALF_PERIOD cycles.
- A timeout gives poll duration = TIMEOUT_CYCLES.
- ready deasserts the cycle after strobe and reasserts the cycle after done.

## Test plan
- Write with address=0x5A3, data=0xC7, and eeprom_do tied high. Decode di at the clk rising edges:
  - Frame 1 must be 10011000000000.
  - Frame 2 must be 101 10110100011 11000111.
  - Frame 3 must be 10000000000000.
  - done must arrive 821 cycles after strobe, with error=0.
- Check inter-frame spacing: cs is low for exactly 4 cycles between frames, and clk never rises while cs=0.
- Busy model: hold eeprom_do=0 for 1000 cycles after POLL entry, then 1. done must arrive late by the whole number of 8-cycle windows needed to observe the 1, and error=0.
- Timeout: eeprom_do held at 0. After 120000 poll cycles error=1, EWDS is still sent, and done pulses. The next strobe clears error.
- Strobe pulses during WRITE_SHIFT carrying different address and data produce no change to the serial stream.
- Assert reset_n=0 mid-WRITE_SHIFT. Outputs drop to reset values immediately and ready=1. A fresh strobe then produces a complete, correct three-frame sequence.
